flag_branch_unit: RTL
=====================

# flag_branch_unit

Consumer stage directly downstream of the 32-bit compare unit. Holds the architectural flag register (N,Z,C,V), written from each compare result, and resolves conditional branches against it. Tracks compares that have been issued but have not yet returned, and stalls a branch until its flags are current. Delivers taken/not-taken plus the next-PC target through a valid/ready handshake to the fetch stage.

## Interface
- `ADDR_W`, default 32: PC/target width.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmp_issue` in 1: pulse marking a compare issued upstream; its flags are now outstanding.
- `cmp_issue_ok` out 1: high when `cnt != 3`. Upstream must not pulse `cmp_issue` while low.
- `cmp_valid` in 1: compare result present this cycle.
- `cmp_flag` in 4: compare flags. Bit 3 = N (1000), bit 2 = Z (0100), bit 1 = C (0010), bit 0 = V (0001).
- `br_valid` in 1, `br_ready` out 1: branch request handshake.
- `br_cond` in 4: condition code.
- `br_pc` in ADDR_W: PC of the branch.
- `br_offset` in ADDR_W: two's-complement displacement.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_taken` out 1: branch taken.
- `res_illegal` out 1: condition code was reserved.
- `res_target` out ADDR_W: next PC.
- `flag_q` out 4: current flag register.

## Operation
- **Flag register.** `flag_next = cmp_valid ? cmp_flag : flag_q`, registered every cycle. Flags are stored verbatim; no one-hot check.
- **Outstanding counter `cnt`** (2 bits, 0..3).
  - `cnt_next = cnt + cmp_issue - (cmp_valid && cnt != 0)`.
  - Issue and valid in the same cycle leave `cnt` unchanged.
  - `cmp_valid` at `cnt == 0` updates the flags but does not underflow.
  - `cmp_issue` at `cnt == 3` without `cmp_valid` is a protocol violation; `cnt` saturates at 3.
- **Condition codes.** 0 AL (1), 1 EQ Z, 2 NE !Z, 3 LT N, 4 GE !N, 5 GT !N&!Z, 6 LE N|Z, 7 CS C, 8 CC !C, 9 VS V, 10 VC !V, 11 NV (0). Codes 12–15 are reserved: not taken, `res_illegal=1`.
- **Target.** Taken gives `br_pc + br_offset`; not taken gives `br_pc + 4`. Both wrap modulo 2^ADDR_W.
- **FSM states IDLE, WAIT, HOLD.**
  - IDLE: `br_ready=1`. On `br_valid`, capture `br_cond`, `br_pc` and `br_offset`.
    - If `cnt_next == 0`, evaluate against `flag_next`, load the result registers and go to HOLD.
    - Otherwise go to WAIT.
  - WAIT: `br_ready=0`. In the first cycle with `cnt_next == 0`, evaluate the captured request against `flag_next` (this bypasses a same-cycle `cmp_valid`), load the results and go to HOLD.
  - HOLD: `res_valid=1` and the result registers are stable. On `res_ready`, go to IDLE.
- **Concurrency.** `cmp_issue`/`cmp_valid` are honoured in every state, independent of branch flow.
- **Reset mid-operation** drops any captured or held branch with no result emitted.

## Timing
- **Reset values:** state IDLE, `flag_q=0000`, `cnt=0`, `res_valid=0`, `res_taken=0`, `res_illegal=0`, `res_target=0`. Consequently `br_ready=1` and `cmp_issue_ok=1`.
- **No pending compares:** branch accepted at cycle T gives `res_valid` at T+1.
- **Pending compare:** if the last outstanding `cmp_valid` arrives at cycle R, `res_valid` rises at R+1, using that `cmp_flag`.
- **Throughput:** at most one branch per 2 cycles, since `br_ready` is low during HOLD and at least one IDLE cycle follows.
- **Flag update:** `flag_q` reflects `cmp_flag` one cycle after `cmp_valid`.
- `res_*` are registered outputs. `br_ready` and `cmp_issue_ok` are decoded from registered state only.

## Structure
- **Package `flag_branch_pkg`:** condition-code constants (`COND_AL`..`COND_NV`), flag bit indices (`FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`), FSM state encoding, `NT_INC=4`.
- **Sub-module `cond_eval`:** combinational. Takes 4-bit cond and 4-bit flags; produces `taken` and `illegal`. Instantiated once.

## Test plan
- **EQ, no pending compares.** After reset: `cmp_valid` with `cmp_flag=0100`, then branch `br_cond=1`, `br_pc=0x100`, `br_offset=0x20` accepted at T → `res_valid` at T+1, `taken=1`, `target=0x120`.
- **Wait then bypass.** `cmp_issue`; branch `br_cond=3`, `br_pc=0x200`, `br_offset=0xFFFFFFF0` → FSM in WAIT, `br_ready=0`. Then `cmp_valid` with `1000` at R → `res_valid` at R+1, `taken=1`, `target=0x1F0`.
- **Not taken and wrap.**
  - NE with `flag_q=0100`, `br_pc=0xFFFFFFFC` → `taken=0`, `target=0x00000000`.
  - AL with `br_pc=0xFFFFFFF0`, `br_offset=0x20` → `target=0x10`.
- **Counter rules.**
  - Three `cmp_issue` pulses → `cmp_issue_ok=0`.
  - Simultaneous `cmp_issue` + `cmp_valid` → `cnt` unchanged.
  - `cmp_valid` at `cnt=0` → `flag_q` updates, `cnt` stays 0.
- **Result backpressure and reserved code.** `res_ready=0` for 5 cycles in HOLD → outputs stable. Code 13 → `taken=0`, `illegal=1`, `target=pc+4`.
- **Reset mid-operation.** `rst` asserted during WAIT → next cycle IDLE, `cnt=0`, `flag_q=0`, no `res_valid` ever produced for the dropped branch.

Source files
------------

// File: rtl/flag_branch_pkg.sv
// flag_branch_pkg: shared constants and state encoding for the flag/branch unit
package flag_branch_pkg;
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_LT = 4'd3;
  localparam logic [3:0] COND_GE = 4'd4;
  localparam logic [3:0] COND_GT = 4'd5;
  localparam logic [3:0] COND_LE = 4'd6;
  localparam logic [3:0] COND_CS = 4'd7;
  localparam logic [3:0] COND_CC = 4'd8;
  localparam logic [3:0] COND_VS = 4'd9;
  localparam logic [3:0] COND_VC = 4'd10;
  localparam logic [3:0] COND_NV = 4'd11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int NT_INC = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// cond_eval: resolves a condition code against N/Z/C/V flags
module cond_eval
  import flag_branch_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken,
  output logic       o_illegal
);
  logic w_n, w_z, w_c, w_v;
  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];
  assign o_illegal = i_cond > COND_NV;
  // decode the condition; reserved codes and NV resolve to not taken
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_AL: o_taken = 1'b1;
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_LT: o_taken = w_n;
      COND_GE: o_taken = !w_n;
      COND_GT: o_taken = !w_n && !w_z;
      COND_LE: o_taken = w_n || w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = !w_c;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = !w_v;
      default: o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: flag register, outstanding-compare tracking and branch resolution
module flag_branch_unit
  import flag_branch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmp_issue,
  output logic              cmp_issue_ok,
  input  logic              cmp_valid,
  input  logic [3:0]        cmp_flag,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic              res_illegal,
  output logic [ADDR_W-1:0] res_target,
  output logic [3:0]        flag_q
);
  state_t            r_state;
  logic [3:0]        r_flag;
  logic [1:0]        r_cnt;
  logic [3:0]        r_cond;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_off;
  logic              r_taken;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_target;
  logic              w_dec;
  logic [1:0]        w_cnt_next;
  logic [3:0]        w_flag_next;
  logic              w_idle;
  logic [3:0]        w_cond;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_off;
  logic              w_taken;
  logic              w_illegal;
  logic [ADDR_W-1:0] w_target;
  assign w_dec       = cmp_valid && r_cnt != 2'd0;
  assign w_cnt_next  = (r_cnt == 2'd3 && cmp_issue && !w_dec) ? 2'd3
                     : r_cnt + {1'b0, cmp_issue} - {1'b0, w_dec};
  assign w_flag_next = cmp_valid ? cmp_flag : r_flag;
  assign w_idle      = r_state == S_IDLE;
  assign w_cond      = w_idle ? br_cond : r_cond;
  assign w_pc        = w_idle ? br_pc : r_pc;
  assign w_off       = w_idle ? br_offset : r_off;
  assign w_target    = w_taken ? w_pc + w_off : w_pc + ADDR_W'(NT_INC);
  cond_eval u_cond_eval (
    .i_cond   (w_cond),
    .i_flags  (w_flag_next),
    .o_taken  (w_taken),
    .o_illegal(w_illegal)
  );
  // flags, outstanding counter and the branch accept/wait/hold sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_flag    <= 4'd0;
      r_cnt     <= 2'd0;
      r_cond    <= 4'd0;
      r_pc      <= '0;
      r_off     <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_target  <= '0;
    end else begin
      r_flag <= w_flag_next;
      r_cnt  <= w_cnt_next;
      case (r_state)
        S_IDLE: if (br_valid) begin
          r_cond <= br_cond;
          r_pc   <= br_pc;
          r_off  <= br_offset;
          if (w_cnt_next == 2'd0) begin
            r_taken   <= w_taken;
            r_illegal <= w_illegal;
            r_target  <= w_target;
            r_state   <= S_HOLD;
          end else r_state <= S_WAIT;
        end
        S_WAIT: if (w_cnt_next == 2'd0) begin
          r_taken   <= w_taken;
          r_illegal <= w_illegal;
          r_target  <= w_target;
          r_state   <= S_HOLD;
        end
        S_HOLD: if (res_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign br_ready     = w_idle;
  assign cmp_issue_ok = r_cnt != 2'd3;
  assign res_valid    = r_state == S_HOLD;
  assign res_taken    = r_taken;
  assign res_illegal  = r_illegal;
  assign res_target   = r_target;
  assign flag_q       = r_flag;
endmodule
